// File: rtl/instruction_fetch.sv
// Pipeline IF stage: fetch PC, word-addressed instruction memory, registered IR/PC to decode.
// Latency: 1 cycle from fetch_pc to IR/PC; throughput 1 instruction per unstalled cycle, redirect costs 1 bubble.
// Backpressure: stall holds fetch_pc and IR/PC/IF_valid; redirect overrides stall; HALT ignores both until reset.
// Optional feature macro: IF_EARLY_JUMP_EN (resolve j at fetch with zero bubbles).
module instruction_fetch #(
    parameter int          IMEM_DEPTH = 128,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [31:0]   imem_wdata,
    output logic [31:0]   IR,
    output logic [31:0]   PC,
    output logic          IF_valid,
    output logic          fetch_fault,
    output logic [31:0]   fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_nxt;
    logic [31:0] ir_nxt;
    logic [31:0] pc_nxt;
    logic        valid_nxt;
    logic [31:0] count_nxt;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] instr;
    logic [31:0] fetch_pc_plus4;
    logic [31:0] next_pc;
    logic        pc_misaligned;
    logic        pc_out_of_range;
    logic        bad_addr;

    // Program image load port; not reset so the image survives a reset pulse.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // Combinational read; a same-edge write is only visible on the following cycle.
    assign instr = imem[fetch_pc[AW+1:2]];

    assign fetch_pc_plus4  = fetch_pc + 32'd4;
    assign pc_misaligned   = (fetch_pc[1:0] != 2'b00);
    assign pc_out_of_range = ({2'b00, fetch_pc[31:2]} >= 32'(IMEM_DEPTH));
    assign bad_addr        = pc_misaligned | pc_out_of_range;

    // Sequential fetch address; an unconditional j can be taken here without a bubble.
    always_comb begin
        next_pc = fetch_pc_plus4;
`ifdef IF_EARLY_JUMP_EN
        if (instr[31:26] == 6'd2) begin
            next_pc = {fetch_pc_plus4[31:28], instr[25:0], 2'b00};
        end
`endif
    end

    // Next-state and next-output logic: redirect beats stall beats fault beats normal fetch.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        ir_nxt       = IR;
        pc_nxt       = PC;
        valid_nxt    = IF_valid;
        count_nxt    = fetch_count;
        case (state)
            ST_RUN: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_pc;
                    ir_nxt       = 32'd0;
                    valid_nxt    = 1'b0;
                end else if (stall) begin
                    // everything holds
                end else if (bad_addr) begin
                    state_nxt = ST_HALT;
                    ir_nxt    = 32'd0;
                    valid_nxt = 1'b0;
                end else begin
                    ir_nxt       = instr;
                    pc_nxt       = fetch_pc_plus4;
                    valid_nxt    = 1'b1;
                    fetch_pc_nxt = next_pc;
                    if (fetch_count != 32'hFFFF_FFFF) begin
                        count_nxt = fetch_count + 32'd1;
                    end
                end
            end
            ST_HALT: begin
                // sticky until reset; keep decode fed with bubbles
                ir_nxt    = 32'd0;
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = ST_HALT;
                ir_nxt    = 32'd0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            IR          <= 32'd0;
            PC          <= 32'd0;
            IF_valid    <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            IR          <= ir_nxt;
            PC          <= pc_nxt;
            IF_valid    <= valid_nxt;
            fetch_count <= count_nxt;
        end
    end

    assign fetch_fault = (state == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed plan steps, then random traffic against a reference model.
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Reference model follows the architectural rules (priority of redirect/stall/fault/fetch), not the RTL structure.
module tb_instruction_fetch;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_we;
    logic [6:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] IR;
    logic [31:0] PC;
    logic        IF_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_pcout;
    logic        m_valid;
    logic        m_halt;
    logic [31:0] m_count;

    instruction_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .IR(IR), .PC(PC), .IF_valid(IF_valid),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_pcout = 32'h0;
        m_valid = 1'b0; m_halt = 1'b0; m_count = 32'h0;
    endtask

    // One rising edge of the architectural machine, using pre-edge inputs and state.
    task automatic model_edge();
        logic [31:0] instr;
        logic [31:0] p4;
        instr = m_mem[(m_pc >> 2) % DEPTH];
        p4 = m_pc + 32'd4;
        if (rst && !m_halt) begin
            if (redirect_valid) begin
                m_pc = redirect_pc; m_ir = 0; m_valid = 0;
            end else if (stall) begin
            end else if ((m_pc % 4) != 0 || (m_pc / 4) >= DEPTH) begin
                m_halt = 1; m_ir = 0; m_valid = 0;
            end else begin
                m_ir = instr; m_pcout = p4; m_valid = 1;
                m_pc = p4;
`ifdef IF_EARLY_JUMP_EN
                if ((instr >> 26) == 2) m_pc = (p4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
`endif
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            end
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".IR"}, IR, m_ir);
        chk({tag, ".PC"}, PC, m_pcout);
        chk({tag, ".IF_valid"}, {31'd0, IF_valid}, {31'd0, m_valid});
        chk({tag, ".fetch_fault"}, {31'd0, fetch_fault}, {31'd0, m_halt});
        chk({tag, ".fetch_count"}, fetch_count, m_count);
    endtask

    task automatic step(input string tag, input logic s, input logic rv, input logic [31:0] rpc,
                        input logic we, input logic [6:0] wa, input logic [31:0] wd);
        stall = s; redirect_valid = rv; redirect_pc = rpc;
        imem_we = we; imem_waddr = wa; imem_wdata = wd;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any edge.
    task automatic reset_pulse(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        chk({tag, ".IR"}, IR, 32'h0);
        chk({tag, ".PC"}, PC, 32'h0);
        chk({tag, ".IF_valid"}, {31'd0, IF_valid}, 32'd0);
        chk({tag, ".fetch_fault"}, {31'd0, fetch_fault}, 32'd0);
        chk({tag, ".fetch_count"}, fetch_count, 32'h0);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) == 0) begin
            // j with a target mostly inside the memory
            w = {6'd2, 26'($urandom_range(0, DEPTH + 8))};
        end else if (w[31:26] == 6'd2) begin
            w[31:26] = 6'd3;
        end
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        logic [31:0] rpc;
        int halt_run;
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_we = 1'b0; imem_waddr = 7'd0; imem_wdata = 32'h0;
        foreach (m_mem[i]) m_mem[i] = 32'h0;
        model_reset();
        #1;
        compare_all("reset");

        // load image while reset is held (writes work during reset)
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 4) w = 32'h1111_0000 + 32'(i);
            else w = rand_instr();
            step("load", 1'b0, 1'b0, 32'h0, 1'b1, 7'(i), w);
        end
        rst = 1'b1;

        step("fetch0", 0, 0, 0, 0, 0, 0);
        chk("fetch0.IR_const", IR, 32'h1111_0000);
        chk("fetch0.PC_const", PC, 32'h4);
        step("fetch1", 0, 0, 0, 0, 0, 0);
        chk("fetch1.IR_const", IR, 32'h1111_0001);
        chk("fetch1.PC_const", PC, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1, 0, 0, 0, 0, 0);
            chk("stall.IR_const", IR, 32'h1111_0001);
            chk("stall.count_const", fetch_count, 32'd2);
        end
        step("fetch2", 0, 0, 0, 0, 0, 0);
        step("fetch3", 0, 0, 0, 0, 0, 0);
        chk("fetch3.IR_const", IR, 32'h1111_0003);
        chk("fetch3.count_const", fetch_count, 32'd4);

        // redirect with stall: bubble then IMEM[16]
        step("redir", 1, 1, 32'h40, 0, 0, 0);
        chk("redir.IR_const", IR, 32'h0);
        chk("redir.valid_const", {31'd0, IF_valid}, 32'd0);
        step("redir_tgt", 0, 0, 0, 0, 0, 0);
        chk("redir_tgt.PC_const", PC, 32'h44);

        // misaligned redirect: bubble, then halt; later redirects ignored
        step("bad_redir", 0, 1, 32'h6, 0, 0, 0);
        step("halt", 0, 0, 0, 0, 0, 0);
        chk("halt.fault_const", {31'd0, fetch_fault}, 32'd1);
        chk("halt.IR_const", IR, 32'h0);
        step("halt_redir", 0, 1, 32'h40, 0, 0, 0);
        chk("halt_redir.fault_const", {31'd0, fetch_fault}, 32'd1);
        // memory writes still work in HALT
        step("halt_wr", 0, 0, 0, 1, 7'd0, 32'h0800_0008);

        reset_pulse("rst_pulse");
        step("jmp0", 0, 0, 0, 0, 0, 0);
        chk("jmp0.IR_const", IR, 32'h0800_0008);
        step("jmp1", 0, 0, 0, 0, 0, 0);
`ifdef IF_EARLY_JUMP_EN
        chk("jmp1.PC_const", PC, 32'h24);
        chk("jmp1.IR_mem", IR, m_mem[8]);
`else
        chk("jmp1.PC_const", PC, 32'h8);
        chk("jmp1.IR_mem", IR, m_mem[1]);
`endif

        // random traffic
        halt_run = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) rpc = $urandom;
            else rpc = {23'd0, 7'($urandom_range(0, DEPTH - 1)), 2'b00};
            step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), rpc,
                 ($urandom_range(0, 7) == 0), 7'($urandom), rand_instr());
            if (m_halt) halt_run++;
            if (halt_run > 4) begin
                reset_pulse("rand_rst");
                halt_run = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Pipeline IF stage, directly upstream of the decode stage. Holds the fetch PC and a word-addressed instruction memory, and registers one instruction per cycle into `IR`/`PC` for decode to consume. Supports stall, redirect from branch/jump resolution, a sticky fault halt and a saturating fetch counter. Program images are loaded through a dedicated write port.

## Interface
- `IMEM_DEPTH`, 128: instruction memory size in 32-bit words (power of two, ≥ 2).
- `RESET_PC`, 32'h0000_0000: fetch address after reset (word aligned).

- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, asynchronous assert, active-low (0 = reset).
- `stall`  in  1: hold the fetch PC and the `IR`/`PC`/`IF_valid` outputs.
- `redirect_valid`  in  1: branch/jump taken; load `redirect_pc` and flush.
- `redirect_pc`  in  32: redirect target byte address.
- `imem_we`  in  1: instruction memory write enable.
- `imem_waddr`  in  log2(IMEM_DEPTH): word address for the write.
- `imem_wdata`  in  32: write data.
- `IR`  out  32: registered instruction to decode.
- `PC`  out  32: registered byte address of `IR` plus 4.
- `IF_valid`  out  1: `IR` holds a real instruction (0 = bubble, `IR` = 0).
- `fetch_fault`  out  1: sticky; fetch address was misaligned or out of range.
- `fetch_count`  out  32: number of instructions delivered, saturating.

## Operation
- Internal `fetch_pc` register. Combinational read: `instr = IMEM[fetch_pc[log2(IMEM_DEPTH)+1:2]]`.
- FSM with two states:
  - RUN: normal fetch.
  - HALT: entered from RUN on a non-stalled, non-redirected cycle when `fetch_pc[1:0] != 0` or `fetch_pc[31:2] >= IMEM_DEPTH`.
  - HALT exits only on reset. In HALT: `IR = 0`, `IF_valid = 0`, `fetch_fault = 1`, and `stall` and redirect are ignored.
- RUN, per rising edge, in priority order:
  1. `redirect_valid`: `fetch_pc <= redirect_pc`, `IR <= 0`, `IF_valid <= 0`, `PC` unchanged. Stall is ignored.
  2. `stall`: every register holds.
  3. Fault condition: go to HALT, `IR <= 0`, `IF_valid <= 0`.
  4. Otherwise: `IR <= instr`, `PC <= fetch_pc + 4`, `IF_valid <= 1`, `fetch_pc <= next_pc`, `fetch_count++`.
- `next_pc = fetch_pc + 4`, modulo 2^32. The early-jump option below changes this.
- `fetch_count` increments only in case 4 and saturates at 32'hFFFF_FFFF.
- Instruction memory write: on any edge with `imem_we`, in any state, including during reset. A same-cycle fetch of the same word returns the old data. Memory contents are not cleared by reset.
- Opcode 0 with funct 0 (`IR` = 0) is the bubble/NOP the decode stage ignores.

## Timing
- Reset (`rst` = 0), asynchronous:
  - `fetch_pc = RESET_PC`, state RUN.
  - `IR = 0`, `PC = 0`, `IF_valid = 0`, `fetch_fault = 0`, `fetch_count = 0`.
- First instruction appears in `IR` on the first rising edge after `rst` deasserts, provided `stall` = 0.
- Fetch-to-output latency: 1 cycle. Throughput: 1 instruction per unstalled cycle.
- Redirect penalty: 1 bubble. The instruction at `redirect_pc` appears 2 edges after the redirect is asserted.
- Reset asserted mid-stall or mid-redirect: outputs go to reset values immediately and any pending redirect is lost.
- Redirect to a bad address: one bubble (the redirect edge), then HALT on the next unstalled edge.

## Configuration
- `IF_EARLY_JUMP_EN` defined:
  - When `instr[31:26] == 6'd2` (j) is delivered in case 4, `next_pc = {fetch_pc_plus4[31:28], instr[25:0], 2'b00}`.
  - The jump costs zero bubbles. The j is still delivered in `IR` with `IF_valid` = 1.
  - An external redirect in the same cycle still wins.
- Not defined: j is treated like any other instruction (`next_pc = fetch_pc + 4`), and the downstream stage must redirect.

## Test plan
- Load words 0–3 with 32'h1111_0000–32'h1111_0003, release reset with no stall:
  - `IR` = 32'h1111_0000 / `PC` = 4, then 32'h1111_0001 / `PC` = 8, and so on.
  - `fetch_count` = 4 after 4 edges.
- Assert `stall` for 3 cycles after the second fetch: `IR`, `PC`, `IF_valid` and `fetch_count` hold at 32'h1111_0001 / 8 / 1 / 2.
- Assert `redirect_valid` with `redirect_pc` = 32'h40 together with `stall`:
  - Next edge: `IR` = 0, `IF_valid` = 0.
  - Following edge: `IR` = IMEM[16], `PC` = 32'h44.
- Redirect to 32'h6 (misaligned): one bubble, then `fetch_fault` = 1 and `IR` = 0. Further redirects are ignored until `rst` = 0.
- With `IF_EARLY_JUMP_EN`, put `j 0x20` (32'h0800_0008) at word 0:
  - `IR` = 32'h0800_0008, then IMEM[8] with `PC` = 32'h24, with no bubble.
  - Without the macro, the second output is IMEM[1].
- Pulse `rst` low mid-run for 1 ns between edges: outputs clear immediately, then fetch restarts at `RESET_PC`. IMEM contents persist.
